// File: rtl/cr_huf_comp_lut_bank_ring_if.sv
`default_nettype none
// ============================================================================
// Module   : cr_huf_comp_lut_bank_ring_if
// Purpose  : Bundle of writer / symbol-assembler signals for the long-symbol
//            LUT bank ring.
//            master : the Huffman-table writer plus the symbol assembler.
//            slave  : the bank ring itself.
// Ports    : write side  wr_val, wr_addr, wr_data, wr_seq_id, wr_done,
//                        wr_full, wr_overflow
//            read side   head_vld, head_seq_id, rd, rd_addr, rd_data_val,
//                        rd_data, ret_ack, seq_chk_id, seq_err, bank_cnt
// Revision : 1.0  initial release
// ============================================================================
interface cr_huf_comp_lut_bank_ring_if #(
  parameter int N_BANKS = 2,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 6,
  parameter int SEQID_W = 4
) ();
  localparam int c_CNT_W = $clog2(N_BANKS + 1);

  logic               wr_val;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic [SEQID_W-1:0] wr_seq_id;
  logic               wr_done;
  logic               wr_full;
  logic               wr_overflow;
  logic               head_vld;
  logic [SEQID_W-1:0] head_seq_id;
  logic               rd;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_data_val;
  logic [DATA_W-1:0]  rd_data;
  logic               ret_ack;
  logic [SEQID_W-1:0] seq_chk_id;
  logic               seq_err;
  logic [c_CNT_W-1:0] bank_cnt;

  modport master (
    output wr_val, wr_addr, wr_data, wr_seq_id, wr_done,
    output rd, rd_addr, ret_ack, seq_chk_id,
    input  wr_full, wr_overflow, head_vld, head_seq_id,
    input  rd_data_val, rd_data, seq_err, bank_cnt
  );

  modport slave (
    input  wr_val, wr_addr, wr_data, wr_seq_id, wr_done,
    input  rd, rd_addr, ret_ack, seq_chk_id,
    output wr_full, wr_overflow, head_vld, head_seq_id,
    output rd_data_val, rd_data, seq_err, bank_cnt
  );
endinterface
`default_nettype wire

// File: rtl/cr_huf_comp_lut_bank_ring.sv
`default_nettype none
// ============================================================================
// Module   : cr_huf_comp_lut_bank_ring
// Purpose  : Ring of N_BANKS long-symbol Huffman LUT banks. The table writer
//            fills banks strictly in ring order, the symbol assembler reads
//            and releases them strictly in ring order. Each bank carries a
//            FREE/FILL/READY state and the seq_id of its table. Reads return
//            data with a fixed 1-cycle latency.
// Ports    : clk, rst_n (async assert, active-low)
//            bus (slave) : write, read/release, status and bank_cnt signals
// Revision : 1.0  initial release
// ============================================================================
module cr_huf_comp_lut_bank_ring #(
  parameter int N_BANKS = 2,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 6,
  parameter int SEQID_W = 4
) (
  input wire clk,
  input wire rst_n,
  cr_huf_comp_lut_bank_ring_if.slave bus
);
  localparam int c_PTR_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam int c_CNT_W = $clog2(N_BANKS + 1);
  localparam int c_DEPTH = 1 << ADDR_W;
  localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(N_BANKS - 1);

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } bank_state_t;

  bank_state_t        r_state  [N_BANKS];
  logic [SEQID_W-1:0] r_seq_id [N_BANKS];
  logic [DATA_W-1:0]  r_mem    [N_BANKS][c_DEPTH];

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_bank_cnt;
  logic               r_wr_overflow;
  logic               r_seq_err;
  logic               r_rd_data_val;
  logic [DATA_W-1:0]  r_rd_data;

  logic w_wr_full;
  logic w_head_vld;
  logic w_wr_any;
  logic w_wr_accept;
  logic w_open;
  logic w_close;
  logic w_release;
  logic w_rd_accept;

  // Both flags come from registered state only, so a release of the bank at
  // wr_ptr cannot unblock a write in the same cycle.
  assign w_wr_full   = (r_state[r_wr_ptr] == ST_READY);
  assign w_head_vld  = (r_state[r_rd_ptr] == ST_READY);

  assign w_wr_any    = bus.wr_val | bus.wr_done;
  assign w_wr_accept = w_wr_any & ~w_wr_full;
  // A bank leaves FREE on its first accepted beat, or on a bare wr_done
  // (empty table).
  assign w_open      = w_wr_accept & (r_state[r_wr_ptr] == ST_FREE);
  assign w_close     = bus.wr_done & ~w_wr_full;
  assign w_release   = bus.ret_ack & w_head_vld;
  assign w_rd_accept = bus.rd & w_head_vld;

  // The fill bank can never be READY while written and the head bank is
  // always READY when released, so the two branches never target the same
  // bank in one cycle.
  generate
    for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_bank
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state[gi]  <= ST_FREE;
          r_seq_id[gi] <= '0;
        end else if (w_release && (r_rd_ptr == c_PTR_W'(gi))) begin
          r_state[gi] <= ST_FREE;
        end else if (w_wr_accept && (r_wr_ptr == c_PTR_W'(gi))) begin
          r_state[gi] <= bus.wr_done ? ST_READY : ST_FILL;
          if (r_state[gi] == ST_FREE) begin
            r_seq_id[gi] <= bus.wr_seq_id;
          end
        end
      end
    end
  endgenerate

  // Table storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus.wr_val && !w_wr_full) begin
      r_mem[r_wr_ptr][bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_bank_cnt    <= '0;
      r_wr_overflow <= 1'b0;
      r_seq_err     <= 1'b0;
      r_rd_data_val <= 1'b0;
      r_rd_data     <= '0;
    end else begin
      if (w_close) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_W'(1);
      end
      if (w_release) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_open, w_release})
        2'b10:   r_bank_cnt <= r_bank_cnt + c_CNT_W'(1);
        2'b01:   r_bank_cnt <= r_bank_cnt - c_CNT_W'(1);
        default: r_bank_cnt <= r_bank_cnt;
      endcase
      r_wr_overflow <= w_wr_any & w_wr_full;
      r_seq_err     <= w_release & (bus.seq_chk_id != r_seq_id[r_rd_ptr]);
      r_rd_data_val <= w_rd_accept;
      // Read and release may coincide; the read still sees the old table.
      if (w_rd_accept) begin
        r_rd_data <= r_mem[r_rd_ptr][bus.rd_addr];
      end
    end
  end

  assign bus.wr_full     = w_wr_full;
  assign bus.wr_overflow = r_wr_overflow;
  assign bus.head_vld    = w_head_vld;
  assign bus.head_seq_id = w_head_vld ? r_seq_id[r_rd_ptr] : '0;
  assign bus.rd_data_val = r_rd_data_val;
  assign bus.rd_data     = r_rd_data;
  assign bus.seq_err     = r_seq_err;
  assign bus.bank_cnt    = r_bank_cnt;
endmodule
`default_nettype wire

// File: tb/tb_cr_huf_comp_lut_bank_ring.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cr_huf_comp_lut_bank_ring
// Purpose  : Self-checking bench for cr_huf_comp_lut_bank_ring. Three rings
//            (N_BANKS = 2, 3, 1) share one stimulus set; sel routes the
//            strobes to one ring and muxes its outputs back. Read data is
//            checked through an expected-value queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_cr_huf_comp_lut_bank_ring;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    sel = 2'd0;
  logic          wr_val = 1'b0, wr_done = 1'b0, rd = 1'b0, ret_ack = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [SW-1:0] wr_seq_id = '0, seq_chk_id = '0;

  cr_huf_comp_lut_bank_ring_if #(.N_BANKS(2), .DATA_W(DW), .ADDR_W(AW), .SEQID_W(SW)) bus2 ();
  cr_huf_comp_lut_bank_ring_if #(.N_BANKS(3), .DATA_W(DW), .ADDR_W(AW), .SEQID_W(SW)) bus3 ();
  cr_huf_comp_lut_bank_ring_if #(.N_BANKS(1), .DATA_W(DW), .ADDR_W(AW), .SEQID_W(SW)) bus1 ();

  assign {bus2.wr_val, bus2.wr_done, bus2.rd, bus2.ret_ack} = (sel == 2'd0) ? {wr_val, wr_done, rd, ret_ack} : 4'b0;
  assign {bus3.wr_val, bus3.wr_done, bus3.rd, bus3.ret_ack} = (sel == 2'd1) ? {wr_val, wr_done, rd, ret_ack} : 4'b0;
  assign {bus1.wr_val, bus1.wr_done, bus1.rd, bus1.ret_ack} = (sel == 2'd2) ? {wr_val, wr_done, rd, ret_ack} : 4'b0;
  assign {bus2.wr_addr, bus2.wr_data, bus2.wr_seq_id, bus2.rd_addr, bus2.seq_chk_id} = {wr_addr, wr_data, wr_seq_id, rd_addr, seq_chk_id};
  assign {bus3.wr_addr, bus3.wr_data, bus3.wr_seq_id, bus3.rd_addr, bus3.seq_chk_id} = {wr_addr, wr_data, wr_seq_id, rd_addr, seq_chk_id};
  assign {bus1.wr_addr, bus1.wr_data, bus1.wr_seq_id, bus1.rd_addr, bus1.seq_chk_id} = {wr_addr, wr_data, wr_seq_id, rd_addr, seq_chk_id};

  cr_huf_comp_lut_bank_ring #(.N_BANKS(2), .DATA_W(DW), .ADDR_W(AW), .SEQID_W(SW))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  cr_huf_comp_lut_bank_ring #(.N_BANKS(3), .DATA_W(DW), .ADDR_W(AW), .SEQID_W(SW))
    u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));
  cr_huf_comp_lut_bank_ring #(.N_BANKS(1), .DATA_W(DW), .ADDR_W(AW), .SEQID_W(SW))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  // Outputs of the selected ring.
  logic          t_full, t_ovf, t_hvld, t_rdv, t_serr;
  logic [SW-1:0] t_hseq;
  logic [DW-1:0] t_rdd;
  logic [3:0]    t_cnt;
  always_comb begin
    {t_full, t_ovf, t_hvld, t_hseq, t_rdv, t_rdd, t_serr} =
      {bus2.wr_full, bus2.wr_overflow, bus2.head_vld, bus2.head_seq_id, bus2.rd_data_val, bus2.rd_data, bus2.seq_err};
    t_cnt = 4'(bus2.bank_cnt);
    if (sel == 2'd1) begin
      {t_full, t_ovf, t_hvld, t_hseq, t_rdv, t_rdd, t_serr} =
        {bus3.wr_full, bus3.wr_overflow, bus3.head_vld, bus3.head_seq_id, bus3.rd_data_val, bus3.rd_data, bus3.seq_err};
      t_cnt = 4'(bus3.bank_cnt);
    end else if (sel == 2'd2) begin
      {t_full, t_ovf, t_hvld, t_hseq, t_rdv, t_rdd, t_serr} =
        {bus1.wr_full, bus1.wr_overflow, bus1.head_vld, bus1.head_seq_id, bus1.rd_data_val, bus1.rd_data, bus1.seq_err};
      t_cnt = 4'(bus1.bank_cnt);
    end
  end

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the edge. A read pushed before
  // the edge must show up as rd_data_val/rd_data right after it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      check("rd_data_val", 32'(t_rdv), 32'd1);
      check("rd_data", 32'(t_rdd), 32'(exp_q.pop_front()));
    end else if (t_rdv) begin
      n_vec++;
      n_err++;
      $display("FAIL rd_data_val unexpected: got 1, expected 0 (t=%0t)", $time);
    end
  endtask

  task automatic do_reset(input logic [1:0] s);
    rst_n = 1'b0;
    sel   = s;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic fill_table(input logic [SW-1:0] seq, input logic [DW-1:0] base, input int n);
    for (int a = 0; a < n; a++) begin
      wr_val    = 1'b1;
      wr_addr   = AW'(a);
      wr_data   = base ^ DW'(a);
      wr_seq_id = seq;
      wr_done   = (a == n - 1);
      tick();
    end
    wr_val  = 1'b0;
    wr_done = 1'b0;
  endtask

  task automatic read(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    rd      = 1'b1;
    rd_addr = addr;
    exp_q.push_back(exp);
    tick();
    rd = 1'b0;
  endtask

  task automatic ack(input logic [SW-1:0] chk);
    ret_ack    = 1'b1;
    seq_chk_id = chk;
    tick();
    ret_ack = 1'b0;
  endtask

  function automatic logic [DW-1:0] base_of(input int s);
    return 16'h0A0A ^ (DW'(s) << 12);
  endfunction

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } rd_vec_t;
  rd_vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table 3 contents are addr ^ 16'hA5A5.
    vecs[0] = '{6'd5,  16'hA5A0};
    vecs[1] = '{6'd0,  16'hA5A5};
    vecs[2] = '{6'd63, 16'hA59A};
    vecs[3] = '{6'd32, 16'hA585};
    vecs[4] = '{6'd17, 16'hA5B4};

    // ---- reset values (N=2) ----
    repeat (2) @(posedge clk);
    #1;
    check("reset wr_full", 32'(t_full), 0);
    check("reset wr_overflow", 32'(t_ovf), 0);
    check("reset head_vld", 32'(t_hvld), 0);
    check("reset head_seq_id", 32'(t_hseq), 0);
    check("reset rd_data_val", 32'(t_rdv), 0);
    check("reset rd_data", 32'(t_rdd), 0);
    check("reset seq_err", 32'(t_serr), 0);
    check("reset bank_cnt", 32'(t_cnt), 0);
    rst_n = 1'b1;

    // ---- N=2: one full table, back-to-back reads ----
    fill_table(4'd3, 16'hA5A5, 64);
    check("t1 head_vld", 32'(t_hvld), 1);
    check("t1 head_seq_id", 32'(t_hseq), 3);
    check("t1 bank_cnt", 32'(t_cnt), 1);
    check("t1 wr_full", 32'(t_full), 0);
    for (int i = 0; i < 5; i++) begin
      rd      = 1'b1;
      rd_addr = vecs[i].addr;
      exp_q.push_back(vecs[i].exp);
      tick();
    end
    rd = 1'b0;
    ack(4'd3);
    check("t1 release head_vld", 32'(t_hvld), 0);
    check("t1 release bank_cnt", 32'(t_cnt), 0);
    check("t1 release seq_err", 32'(t_serr), 0);
    // rd with no READY head is ignored and rd_data holds.
    rd      = 1'b1;
    rd_addr = 6'd9;
    tick();
    rd = 1'b0;
    check("idle rd rd_data_val", 32'(t_rdv), 0);
    check("idle rd rd_data hold", 32'(t_rdd), 32'(vecs[4].exp));

    // ---- N=2: ring full, overflow, release ----
    fill_table(4'd1, 16'h1100, 8);
    fill_table(4'd2, 16'h2200, 8);
    check("t2 wr_full", 32'(t_full), 1);
    check("t2 bank_cnt", 32'(t_cnt), 2);
    check("t2 head_seq_id", 32'(t_hseq), 1);
    wr_val  = 1'b1;
    wr_addr = 6'd0;
    wr_data = 16'hFFFF;
    tick();
    wr_val = 1'b0;
    check("t2 wr_overflow pulse", 32'(t_ovf), 1);
    check("t2 bank_cnt after drop", 32'(t_cnt), 2);
    tick();
    check("t2 wr_overflow clear", 32'(t_ovf), 0);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check("t2 wr_done overflow", 32'(t_ovf), 1);
    check("t2 wr_full held", 32'(t_full), 1);
    read(6'd0, 16'h1100);
    ret_ack    = 1'b1;
    seq_chk_id = 4'd1;
    check("t2 wr_full during ack", 32'(t_full), 1);
    tick();
    ret_ack = 1'b0;
    check("t2 wr_full after ack", 32'(t_full), 0);
    check("t2 bank_cnt after ack", 32'(t_cnt), 1);
    check("t2 head_seq_id next", 32'(t_hseq), 2);
    check("t2 seq_err match", 32'(t_serr), 0);
    // seq mismatch: pulse, bank still released
    ack(4'd5);
    check("seq_err pulse", 32'(t_serr), 1);
    check("seq_err head_vld", 32'(t_hvld), 0);
    check("seq_err bank_cnt", 32'(t_cnt), 0);
    tick();
    check("seq_err one cycle", 32'(t_serr), 0);
    ack(4'd7);
    check("idle ack seq_err", 32'(t_serr), 0);
    check("idle ack bank_cnt", 32'(t_cnt), 0);

    // ---- N=3: seven tables through the ring ----
    do_reset(2'd1);
    fill_table(4'd0, base_of(0), 8);
    fill_table(4'd1, base_of(1), 8);
    for (int s = 0; s < 7; s++) begin
      check("ring head_vld", 32'(t_hvld), 1);
      check("ring head_seq_id", 32'(t_hseq), 32'(s));
      check("ring bank_cnt", 32'(t_cnt), (s == 6) ? 32'd1 : 32'd2);
      read(AW'(s), base_of(s) ^ DW'(s));
      ack(SW'(s));
      check("ring seq_err", 32'(t_serr), 0);
      if (s + 2 <= 6) fill_table(SW'(s + 2), base_of(s + 2), 8);
    end
    check("ring drained bank_cnt", 32'(t_cnt), 0);
    check("ring drained head_vld", 32'(t_hvld), 0);

    // ---- N=1: same-cycle rd + ret_ack + wr_val on the only bank ----
    do_reset(2'd2);
    fill_table(4'd6, 16'h3300, 16);
    check("n1 wr_full", 32'(t_full), 1);
    check("n1 head_vld", 32'(t_hvld), 1);
    check("n1 bank_cnt", 32'(t_cnt), 1);
    rd         = 1'b1;
    rd_addr    = 6'd9;
    ret_ack    = 1'b1;
    seq_chk_id = 4'd6;
    wr_val     = 1'b1;
    wr_addr    = 6'd9;
    wr_data    = 16'hDEAD;
    exp_q.push_back(16'h3309);
    tick();
    {rd, ret_ack, wr_val} = 3'b000;
    check("n1 head_vld after", 32'(t_hvld), 0);
    check("n1 wr_overflow", 32'(t_ovf), 1);
    check("n1 wr_full after", 32'(t_full), 0);
    check("n1 bank_cnt after", 32'(t_cnt), 0);
    // Empty table (bare wr_done) re-exposes the old contents: the dropped
    // write must not have landed.
    wr_done   = 1'b1;
    wr_seq_id = 4'd7;
    tick();
    wr_done = 1'b0;
    check("n1 empty table head_vld", 32'(t_hvld), 1);
    check("n1 empty table head_seq_id", 32'(t_hseq), 7);
    check("n1 empty table bank_cnt", 32'(t_cnt), 1);
    read(6'd9, 16'h3309);

    // ---- N=3: async reset mid-fill with a read in flight ----
    do_reset(2'd1);
    fill_table(4'd2, 16'h4400, 4);
    wr_val    = 1'b1;
    wr_seq_id = 4'd3;
    wr_addr   = 6'd0;
    tick();
    check("mid-fill bank_cnt", 32'(t_cnt), 2);
    rd      = 1'b1;
    rd_addr = 6'd1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst rd_data_val", 32'(t_rdv), 0);
    check("async rst rd_data", 32'(t_rdd), 0);
    check("async rst head_vld", 32'(t_hvld), 0);
    check("async rst head_seq_id", 32'(t_hseq), 0);
    check("async rst bank_cnt", 32'(t_cnt), 0);
    check("async rst wr_full", 32'(t_full), 0);
    check("async rst wr_overflow", 32'(t_ovf), 0);
    check("async rst seq_err", 32'(t_serr), 0);
    {rd, wr_val} = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("post rst bank_cnt", 32'(t_cnt), 0);
    check("post rst wr_full", 32'(t_full), 0);
    check("post rst head_vld", 32'(t_hvld), 0);
    check("scoreboard drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
